demux_write_sequencer: RTL and testbench
========================================

# demux_write_sequencer

Sequences vector write strobes across the 24 one-hot destinations driven by the 1-to-24 demultiplexer. It accepts one request at a time (base slot, element count) through a valid/ready handshake. It then drives the demux select and data-enable one slot per unstalled cycle, wrapping modulo 24, and signals completion with a one-cycle DONE pulse. It sits between the vector execute/writeback control and the demux feeding the per-slot write enables.

## Interface
- N_DEST, 24, number of demux destinations; legal slot indices 0..N_DEST-1
- SEL_W, 5, width of slot index / select and of length field
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  block can accept a request; equals (state==IDLE)
- REQ_BASE  in  SEL_W  first destination slot
- REQ_LEN  in  SEL_W  number of strobes, 0..N_DEST
- STALL  in  1  downstream not ready; freezes sequencing for the cycle
- ABORT  in  1  terminate the current sequence
- SEL  out  SEL_W  demux select (slot index), registered
- WE  out  1  demux data input / write strobe
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  qualifies DONE: illegal request or aborted; valid only while DONE=1

## Operation
- One clock, CLK; reset is asynchronous and active-low, RST_N.
- States: IDLE, RUN, FIN.
- Registers: state, SEL (index), remaining count cnt (SEL_W bits), err flag.
- Accept = REQ_VALID & REQ_READY, sampled at rising edge in IDLE. REQ_BASE/REQ_LEN are captured only then; later changes are ignored.
- IDLE on accept:
  - REQ_BASE >= N_DEST or REQ_LEN > N_DEST -> FIN, err=1, no strobes.
  - REQ_LEN == 0 -> FIN, err=0, no strobes.
  - otherwise -> RUN, SEL<=REQ_BASE, cnt<=REQ_LEN-1, err=0.
- WE = (state==RUN) & ~STALL & ~ABORT (combinational). A strobe is issued in every cycle with WE=1.
- RUN, each edge:
  - ABORT=1 (priority over STALL): -> FIN, err=1; remaining slots are not written.
  - else STALL=1: hold SEL and cnt.
  - else if cnt==0: -> FIN (last strobe issued this cycle).
  - else: SEL<=(SEL==N_DEST-1)?0:SEL+1, cnt<=cnt-1.
- FIN: DONE=1, ERR=err; next edge -> IDLE unconditionally. STALL and ABORT are ignored in FIN and IDLE.
- SEL holds its last value in FIN and IDLE; WE is never 1 outside RUN.
- Reset (any time, including mid-RUN): state=IDLE, SEL=0, cnt=0, err=0. Outputs: WE=0, DONE=0, ERR=0, BUSY=0, REQ_READY=1. The in-flight sequence is dropped with no DONE pulse.

## Timing
- Accept at edge t: first strobe (SEL=REQ_BASE, WE=1) is in cycle t..t+1. No combinational path from REQ_* to SEL/WE.
- Without stalls, strobes occupy LEN consecutive cycles, DONE follows in the next cycle, and REQ_READY returns the cycle after that. Back-to-back throughput is one request per LEN+2 cycles.
- Each STALL cycle in RUN adds exactly one cycle; SEL is unchanged across stall cycles.
- Illegal or zero-length request: DONE in the cycle right after the accept edge, then IDLE.
- ABORT asserted in RUN: WE=0 in that cycle; DONE/ERR=1 in the next cycle.
- Wrap-around: the index after 23 is 0; a full 24-strobe request starting at any base covers every slot exactly once.

## Test plan
- Reset, then BASE=3, LEN=4, no stall -> WE=1 for 4 cycles with SEL=3,4,5,6; DONE=1 and ERR=0 next cycle; REQ_READY=1 the cycle after.
- BASE=22, LEN=5 -> SEL=22,23,0,1,2. BASE=0, LEN=24 -> all 24 slots, each exactly once.
- BASE=5, LEN=3, STALL high in 2nd and 3rd RUN cycles -> strobes at SEL=5,6,7 spread over 5 cycles; SEL=6 held while stalled; DONE 6 cycles after accept.
- BASE=24 (LEN=2); BASE=0, LEN=25; BASE=0, LEN=0 -> no WE; DONE next cycle with ERR=1, 1, 0 respectively.
- BASE=10, LEN=8, ABORT in 4th RUN cycle -> strobes at SEL=10,11,12 only; DONE/ERR=1 next cycle. Repeat with RST_N pulsed low mid-RUN -> WE, BUSY and DONE drop to 0 immediately, SEL=0, REQ_READY=1, no DONE pulse.
- REQ_VALID held high continuously, with REQ_BASE/REQ_LEN changing while BUSY -> new requests are accepted only in IDLE; in-flight SEL sequence is unaffected by the input changes.

Source files
------------

// File: rtl/demux_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : demux_write_sequencer
// Description : Steps a 1-to-24 demux through consecutive destination slots,
//               one write strobe per unstalled cycle, for a vector write of
//               LEN elements starting at slot BASE (wrapping modulo N_DEST).
//               One request is accepted at a time over a valid/ready
//               handshake. Completion is a one-cycle DONE pulse, and ERR
//               qualifies DONE.
//
// Ports       : clk        - clock, all state updates on the rising edge
//               rst_n      - asynchronous active-low reset
//               req_valid  - request present
//               req_ready  - block is idle and can accept a request
//               req_base   - first destination slot of the request
//               req_len    - number of strobes (0..N_DEST)
//               stall      - downstream not ready, freezes sequencing
//               abort      - terminate the current sequence
//               sel        - registered demux select (slot index)
//               we         - demux data input / write strobe
//               busy       - a request is in flight (RUN or FIN)
//               done       - one-cycle completion pulse
//               err        - illegal or aborted request, valid with done
//
// Revision    : 1.0 - initial release
// ============================================================================
module demux_write_sequencer #(
  parameter int N_DEST = 24,
  parameter int SEL_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_base,
  input  logic [SEL_W-1:0] req_len,
  input  logic             stall,
  input  logic             abort,
  output logic [SEL_W-1:0] sel,
  output logic             we,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // N_DEST itself must be representable, since LEN == N_DEST is legal.
  localparam logic [SEL_W-1:0] c_n_dest = SEL_W'(N_DEST);
  localparam logic [SEL_W-1:0] c_last   = SEL_W'(N_DEST - 1);
  localparam logic [SEL_W-1:0] c_zero   = '0;
  localparam logic [SEL_W-1:0] c_one    = SEL_W'(1);

  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_cnt;
  logic             r_err;

  logic w_accept;
  logic w_illegal;
  logic w_run;

  assign w_accept  = req_valid & (r_state == S_IDLE);
  assign w_illegal = (req_base >= c_n_dest) | (req_len > c_n_dest);
  assign w_run     = (r_state == S_RUN);

  // Abort suppresses the strobe in the very cycle it is seen, so the slot
  // currently presented on sel is never written once abort is raised.
  assign we        = w_run & ~stall & ~abort;
  assign sel       = r_sel;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign err       = (r_state == S_FIN) & r_err;

  // r_cnt holds the number of strobes still owed after the current one,
  // so the last strobe is the one issued while r_cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= c_zero;
      r_cnt   <= c_zero;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_state <= S_FIN;
              r_err   <= 1'b1;
            end else if (req_len == c_zero) begin
              r_state <= S_FIN;
              r_err   <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_sel   <= req_base;
              r_cnt   <= req_len - c_one;
              r_err   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_FIN;
            r_err   <= 1'b1;
          end else if (!stall) begin
            if (r_cnt == c_zero) begin
              r_state <= S_FIN;
            end else begin
              r_sel <= (r_sel == c_last) ? c_zero : r_sel + c_one;
              r_cnt <= r_cnt - c_one;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_write_sequencer
// Description : Self-checking bench for demux_write_sequencer. Requests are
//               checked cycle by cycle against a slot-arithmetic model:
//               strobe k of a request must land on slot (base+k) mod 24.
//               Per-slot hit counts are compared after every request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_write_sequencer;

  localparam int N = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_base = '0;
  logic [4:0] req_len = '0;
  logic       stall = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] sel;
  logic       we;
  logic       busy;
  logic       done;
  logic       err;

  int vectors = 0;
  int miscompares = 0;
  int hits[N];
  int last_sel = 0;

  always #5 clk = ~clk;

  demux_write_sequencer #(.N_DEST(24), .SEL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_len(req_len), .stall(stall), .abort(abort),
    .sel(sel), .we(we), .busy(busy), .done(done), .err(err)
  );

  // One request from the accept cycle through the DONE cycle. The cycle
  // after DONE (IDLE) is the accept cycle of whatever is issued next.
  task automatic do_req(input int base, input int len, input logic [31:0] smask,
                        input int abort_at, input bit hold,
                        output int nstr, output int cyc);
    int k, rc, exp_sel, exp_hits;
    bit legal, aborted, fin, exp_err;
    legal = (base < N) && (len <= N);
    for (int s = 0; s < N; s++) hits[s] = 0;
    k = 0; rc = 0; aborted = 0; cyc = 0;

    @(negedge clk);
    req_valid = 1'b1; req_base = 5'(base); req_len = 5'(len);
    stall = 1'($urandom); abort = 1'($urandom);
    #1;
    vectors++;
    if (req_ready !== 1'b1 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_idle: ready=%b we=%b busy=%b done=%b, required ready=1 we=0 busy=0 done=0",
               req_ready, we, busy, done);
    end

    if (legal && len > 0) begin
      fin = 0;
      while (!fin && rc < 200) begin
        @(negedge clk); cyc++;
        req_valid = hold; req_base = 5'($urandom); req_len = 5'($urandom);
        stall = smask[rc % 32]; abort = (rc == abort_at);
        #1;
        exp_sel = (base + k) % N;
        vectors++;
        if (we !== !(stall || abort) || sel !== 5'(exp_sel) || busy !== 1'b1 ||
            done !== 1'b0 || req_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL run_cycle base=%0d len=%0d rc=%0d: we=%b sel=%0d busy=%b done=%b ready=%b, required we=%b sel=%0d busy=1 done=0 ready=0",
                   base, len, rc, we, sel, busy, done, req_ready, !(stall || abort), exp_sel);
        end
        if (we === 1'b1 && sel < N) hits[sel]++;
        if (abort) begin aborted = 1; fin = 1; end
        else if (!stall) begin k++; if (k == len) fin = 1; end
        rc++;
      end
      if (!fin) begin
        miscompares++;
        $display("FAIL run_timeout: sequence base=%0d len=%0d did not complete, required completion", base, len);
      end
      last_sel = aborted ? (base + k) % N : (base + len - 1) % N;
    end

    @(negedge clk); cyc++;
    req_valid = hold; req_base = 5'($urandom); req_len = 5'($urandom);
    stall = 1'($urandom); abort = 1'($urandom);
    #1;
    exp_err = !legal || aborted;
    vectors++;
    if (done !== 1'b1 || err !== exp_err || we !== 1'b0 || busy !== 1'b1 ||
        req_ready !== 1'b0 || sel !== 5'(last_sel)) begin
      miscompares++;
      $display("FAIL fin_cycle base=%0d len=%0d: done=%b err=%b we=%b busy=%b ready=%b sel=%0d, required done=1 err=%b we=0 busy=1 ready=0 sel=%0d",
               base, len, done, err, we, busy, req_ready, sel, exp_err, last_sel);
    end

    for (int s = 0; s < N; s++) begin
      exp_hits = 0;
      for (int i = 0; i < k; i++) if ((base + i) % N == s) exp_hits++;
      vectors++;
      if (hits[s] !== exp_hits) begin
        miscompares++;
        $display("FAIL slot_hits base=%0d len=%0d slot=%0d: got %0d strobes, required %0d",
                 base, len, s, hits[s], exp_hits);
      end
    end
    nstr = k;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        req_ready !== 1'b1 || sel !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_state: we=%b busy=%b done=%b err=%b ready=%b sel=%0d, required 0 0 0 0 1 0",
               we, busy, done, err, req_ready, sel);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_sel = 0;
  endtask

  task automatic test_basic();
    int nstr, cyc;
    do_req(3, 4, 32'h0, -1, 1'b0, nstr, cyc);
    vectors++;
    if (nstr != 4 || cyc != 5) begin
      miscompares++;
      $display("FAIL basic_timing: strobes=%0d cycles=%0d, required strobes=4 cycles=5", nstr, cyc);
    end
  endtask

  task automatic test_wrap();
    int nstr, cyc;
    do_req(22, 5, 32'h0, -1, 1'b0, nstr, cyc);
    do_req(0, 24, 32'h0, -1, 1'b0, nstr, cyc);
    vectors++;
    if (nstr != 24 || cyc != 25) begin
      miscompares++;
      $display("FAIL full_sweep: strobes=%0d cycles=%0d, required strobes=24 cycles=25", nstr, cyc);
    end
    do_req(17, 24, 32'h0, -1, 1'b0, nstr, cyc);
  endtask

  task automatic test_stall();
    int nstr, cyc;
    do_req(5, 3, 32'h6, -1, 1'b0, nstr, cyc);
    vectors++;
    if (nstr != 3 || cyc != 6) begin
      miscompares++;
      $display("FAIL stall_timing: strobes=%0d cycles=%0d, required strobes=3 cycles=6", nstr, cyc);
    end
  endtask

  task automatic test_illegal();
    int nstr, cyc;
    do_req(24, 2, 32'h0, -1, 1'b0, nstr, cyc);
    do_req(0, 25, 32'h0, -1, 1'b0, nstr, cyc);
    do_req(0, 0, 32'h0, -1, 1'b0, nstr, cyc);
    vectors++;
    if (cyc != 1) begin
      miscompares++;
      $display("FAIL zero_len_timing: cycles=%0d, required 1", cyc);
    end
  endtask

  task automatic test_abort();
    int nstr, cyc;
    do_req(10, 8, 32'h0, 3, 1'b0, nstr, cyc);
    vectors++;
    if (nstr != 3 || cyc != 5) begin
      miscompares++;
      $display("FAIL abort_strobes: strobes=%0d cycles=%0d, required strobes=3 cycles=5", nstr, cyc);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    req_valid = 1'b1; req_base = 5'd10; req_len = 5'd8; stall = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      vectors++;
      if (we !== 1'b1 || sel !== 5'(10 + i)) begin
        miscompares++;
        $display("FAIL pre_reset_run: we=%b sel=%0d, required we=1 sel=%0d", we, sel, 10 + i);
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sel !== 5'd0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_run_reset: we=%b busy=%b done=%b sel=%0d ready=%b, required 0 0 0 0 1",
               we, busy, done, sel, req_ready);
    end
    last_sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || we !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle: done=%b busy=%b we=%b, required 0 0 0", done, busy, we);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nstr, cyc, b, l;
    for (int r = 0; r < 6; r++) begin
      b = $urandom_range(0, N - 1);
      l = $urandom_range(1, N);
      do_req(b, l, 32'h0, -1, 1'b1, nstr, cyc);
      vectors++;
      if (cyc != l + 1) begin
        miscompares++;
        $display("FAIL b2b_timing base=%0d len=%0d: cycles=%0d, required %0d", b, l, cyc, l + 1);
      end
    end
    do_req(4, 2, 32'h0, -1, 1'b0, nstr, cyc);
  endtask

  task automatic test_random();
    int nstr, cyc, b, l, ab;
    for (int r = 0; r < 40; r++) begin
      b  = $urandom_range(0, 26);
      l  = $urandom_range(0, 26);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l + 2) : -1;
      do_req(b, l, $urandom & $urandom, ab, 1'($urandom), nstr, cyc);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_illegal();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
